// File: rtl/clk_sel_ctrl_if.sv
// Signal bundle between the clock-select controller and its surroundings:
// pushbutton and lock inputs, clock-generator reset and mux-select outputs.
interface clk_sel_ctrl_if;
    logic [2:0] req_n;
    logic       dcm_locked;
    logic       dcm_reset;
    logic [1:0] sel;
    logic       sel_valid;
    logic       fault;

    // Controller side
    modport master (
        input  req_n,
        input  dcm_locked,
        output dcm_reset,
        output sel,
        output sel_valid,
        output fault
    );

    // Environment side (buttons, clock generator, clock mux)
    modport slave (
        output req_n,
        output dcm_locked,
        input  dcm_reset,
        input  sel,
        input  sel_valid,
        input  fault
    );
endinterface

// File: rtl/clk_sel_ctrl.sv
// Glitch-free clock source selection controller.
// Debounces three active-low pushbuttons, resets the clock generator and waits
// for lock, then drives the downstream mux select. A source change passes
// through a GAP period with sel_valid low so the mux output never glitches.
// Optional feature: define CLK_SEL_STICKY_EN to keep the last committed sel
// across a lock loss; otherwise every relock restarts on source 0.
module clk_sel_ctrl #(
    parameter logic [15:0] DEB_CYCLES   = 16'd50000,
    parameter logic [7:0]  RST_CYCLES   = 8'd16,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd1000000,
    parameter logic [7:0]  GAP_CYCLES   = 8'd32
) (
    input logic            M_CLOCK,
    input logic            RESET,
    clk_sel_ctrl_if.master bus
);

    localparam logic [15:0] DEB_LAST  = DEB_CYCLES - 16'd1;
    localparam logic [23:0] RST_LAST  = {16'd0, RST_CYCLES} - 24'd1;
    localparam logic [23:0] LOCK_LAST = LOCK_TIMEOUT - 24'd1;
    localparam logic [23:0] GAP_LAST  = {16'd0, GAP_CYCLES} - 24'd1;

    typedef enum logic [2:0] {
        DCM_RST,
        WAIT_LOCK,
        RUN,
        GAP,
        FAULT
    } state_t;

    logic [2:0]       req_meta_q, req_sync_q;
    logic             lock_meta_q, lock_sync_q;
    logic [2:0]       deb_q, deb_d;
    logic [2:0][15:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]       press_q;
    logic             press_any;
    logic [1:0]       press_idx;

    state_t           state_q, state_d;
    logic [23:0]      cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       pending_q, pending_d;

    // Two-flop synchronizers; idle level is high (buttons released)
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            req_meta_q  <= 3'b111;
            req_sync_q  <= 3'b111;
            lock_meta_q <= 1'b1;
            lock_sync_q <= 1'b1;
        end else begin
            req_meta_q  <= bus.req_n;
            req_sync_q  <= req_meta_q;
            lock_meta_q <= bus.dcm_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Per-button debounce: any agreement with the current level restarts the count
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int k = 0; k < 3; k++) begin
            if (req_sync_q[k] != deb_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    deb_d[k] = req_sync_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 16'd1;
                end
            end
        end
    end

    // Debounced levels, counters and one-cycle press pulses on 1->0
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            deb_q     <= 3'b111;
            deb_cnt_q <= '0;
            press_q   <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= deb_q & ~deb_d;
        end
    end

    // Lowest index wins when several presses land in the same cycle
    always_comb begin
        press_any = |press_q;
        press_idx = 2'd0;
        if (press_q[0]) begin
            press_idx = 2'd0;
        end else if (press_q[1]) begin
            press_idx = 2'd1;
        end else if (press_q[2]) begin
            press_idx = 2'd2;
        end
    end

    // FSM state, shared cycle counter, retry count and select registers
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            state_q   <= DCM_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            sel_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 24'd1;
        retry_d       = retry_q;
        sel_d         = sel_q;
        pending_d     = pending_q;
        bus.dcm_reset = 1'b0;
        bus.sel_valid = 1'b0;
        bus.fault     = 1'b0;
        bus.sel       = sel_q;

        unique case (state_q)
            DCM_RST: begin
                bus.dcm_reset = 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
`ifdef CLK_SEL_STICKY_EN
                    // sel is untouched by lock loss, so it still holds the last commit
                    sel_d   = sel_q;
`else
                    sel_d   = 2'd0;
`endif
                end else if (cnt_q == LOCK_LAST) begin
                    cnt_d = '0;
                    if (retry_q == 2'd2) begin
                        state_d = FAULT;
                        retry_d = 2'd3;
                    end else begin
                        state_d = DCM_RST;
                        retry_d = retry_q + 2'd1;
                    end
                end
            end
            RUN: begin
                bus.sel_valid = 1'b1;
                cnt_d         = '0;
                if (!lock_sync_q) begin
                    state_d = DCM_RST;
                end else if (press_any && (press_idx != sel_q)) begin
                    pending_d = press_idx;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (!lock_sync_q) begin
                    state_d = DCM_RST;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    sel_d   = pending_q;
                    cnt_d   = '0;
                end
            end
            FAULT: begin
                bus.dcm_reset = 1'b1;
                bus.fault     = 1'b1;
                cnt_d         = '0;
            end
            default: begin
                state_d = DCM_RST;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl with short timing parameters.
module tb_clk_sel_ctrl;

    localparam logic [15:0] DEB  = 16'd4;
    localparam logic [7:0]  RSTC = 8'd3;
    localparam logic [23:0] LTO  = 24'd16;
    localparam logic [7:0]  GAPC = 8'd8;

`ifdef CLK_SEL_STICKY_EN
    localparam int RELOCK_SEL = 2;
`else
    localparam int RELOCK_SEL = 0;
`endif

    typedef struct {
        string      name;
        logic [2:0] req_n;
        logic       lock;
        int         cycles;
        int         exp_sel;
        int         exp_valid;
        int         exp_dcm_rst;
        int         exp_fault;
    } vec_t;

    logic M_CLOCK;
    logic RESET;
    int   errors;
    int   checks;

    clk_sel_ctrl_if bus ();

    clk_sel_ctrl #(
        .DEB_CYCLES  (DEB),
        .RST_CYCLES  (RSTC),
        .LOCK_TIMEOUT(LTO),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .M_CLOCK(M_CLOCK),
        .RESET  (RESET),
        .bus    (bus)
    );

    initial begin
        M_CLOCK = 1'b0;
        forever #5 M_CLOCK = ~M_CLOCK;
    end

    task automatic tick();
        @(posedge M_CLOCK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int s, input int v, input int d,
                             input int f);
        check({name, " sel"}, int'(bus.sel), s);
        check({name, " sel_valid"}, int'(bus.sel_valid), v);
        check({name, " dcm_reset"}, int'(bus.dcm_reset), d);
        check({name, " fault"}, int'(bus.fault), f);
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] r, input logic l, input int c,
                                input int s, input int v, input int d, input int f);
        vec_t t;
        t.name = n; t.req_n = r; t.lock = l; t.cycles = c;
        t.exp_sel = s; t.exp_valid = v; t.exp_dcm_rst = d; t.exp_fault = f;
        return t;
    endfunction

    vec_t vecs [17];

    initial begin
        errors = 0;
        checks = 0;

        // Starts in RUN with sel=0; each entry holds inputs for 'cycles' edges then checks
        vecs[0]  = mk("p2_deb_done",   3'b011, 1'b1, 6, 0, 1, 0, 0);
        vecs[1]  = mk("p2_gap_enter",  3'b111, 1'b1, 1, 0, 0, 0, 0);
        vecs[2]  = mk("p2_gap_last",   3'b111, 1'b1, 7, 0, 0, 0, 0);
        vecs[3]  = mk("p2_commit",     3'b111, 1'b1, 1, 2, 1, 0, 0);
        vecs[4]  = mk("bounce_low",    3'b110, 1'b1, 3, 2, 1, 0, 0);
        vecs[5]  = mk("bounce_after",  3'b111, 1'b1, 10, 2, 1, 0, 0);
        vecs[6]  = mk("p0_deb_done",   3'b110, 1'b1, 6, 2, 1, 0, 0);
        vecs[7]  = mk("p0_gap_enter",  3'b111, 1'b1, 1, 2, 0, 0, 0);
        vecs[8]  = mk("lock_lost_gap", 3'b111, 1'b0, 3, 2, 0, 1, 0);
        vecs[9]  = mk("relock_wait",   3'b111, 1'b1, 3, 2, 0, 0, 0);
        vecs[10] = mk("relock_run",    3'b111, 1'b1, 1, RELOCK_SEL, 1, 0, 0);
        vecs[11] = mk("p12_deb_done",  3'b001, 1'b1, 6, RELOCK_SEL, 1, 0, 0);
        vecs[12] = mk("p12_gap_enter", 3'b111, 1'b1, 1, RELOCK_SEL, 0, 0, 0);
        vecs[13] = mk("p12_commit",    3'b111, 1'b1, 8, 1, 1, 0, 0);
        vecs[14] = mk("same_sel_deb",  3'b101, 1'b1, 6, 1, 1, 0, 0);
        vecs[15] = mk("same_sel_hold", 3'b111, 1'b1, 8, 1, 1, 0, 0);
        vecs[16] = mk("settle",        3'b111, 1'b1, 4, 1, 1, 0, 0);

        // Reset with lock low, then release and raise lock 10 cycles later
        RESET = 1'b1;
        bus.req_n = 3'b111;
        bus.dcm_locked = 1'b0;
        tick();
        tick();
        tick();
        check_all("reset_state", 0, 0, 1, 0);
        RESET = 1'b0;
        for (int n = 0; n <= 15; n++) begin
            if (n > 0) tick();
            check($sformatf("startup_dcm_reset[%0d]", n), int'(bus.dcm_reset), (n < 3) ? 1 : 0);
            check($sformatf("startup_valid[%0d]", n), int'(bus.sel_valid), (n >= 13) ? 1 : 0);
            if (n == 10) bus.dcm_locked = 1'b1;
        end
        check("startup_sel", int'(bus.sel), 0);

        // Table-driven main function
        for (int i = 0; i < 17; i++) begin
            bus.req_n = vecs[i].req_n;
            bus.dcm_locked = vecs[i].lock;
            for (int c = 0; c < vecs[i].cycles; c++) tick();
            check_all(vecs[i].name, vecs[i].exp_sel, vecs[i].exp_valid, vecs[i].exp_dcm_rst,
                      vecs[i].exp_fault);
        end

        // GAP must last exactly GAPC cycles: press 2 from sel=1, watch sel_valid each cycle
        bus.req_n = 3'b011;
        for (int c = 0; c < 6; c++) tick();
        bus.req_n = 3'b111;
        for (int n = 7; n <= 16; n++) begin
            tick();
            check($sformatf("gap_valid[%0d]", n), int'(bus.sel_valid),
                  (n >= 7 && n <= 14) ? 0 : 1);
            check($sformatf("gap_sel[%0d]", n), int'(bus.sel), (n >= 15) ? 2 : 1);
        end

        // RESET in the middle of GAP
        bus.req_n = 3'b110;
        for (int c = 0; c < 6; c++) tick();
        bus.req_n = 3'b111;
        tick();
        check("midgap_valid", int'(bus.sel_valid), 0);
        RESET = 1'b1;
        tick();
        check_all("midgap_reset", 0, 0, 1, 0);
        RESET = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check_all("midgap_relock", 0, 1, 0, 0);
        for (int c = 0; c < 12; c++) tick();
        check_all("midgap_no_pending", 0, 1, 0, 0);

        // Lock never arrives: three reset pulses, then FAULT
        bus.dcm_locked = 1'b0;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        for (int n = 0; n <= 62; n++) begin
            if (n > 0) tick();
            check($sformatf("timeout_dcm_reset[%0d]", n), int'(bus.dcm_reset),
                  (n >= 57 || (n % 19) < 3) ? 1 : 0);
            check($sformatf("timeout_fault[%0d]", n), int'(bus.fault), (n >= 57) ? 1 : 0);
        end
        check("timeout_valid", int'(bus.sel_valid), 0);
        RESET = 1'b1;
        tick();
        check_all("fault_cleared", 0, 0, 1, 0);
        RESET = 1'b0;
        tick();
        check("fault_stays_clear", int'(bus.fault), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
